// File: rtl/wiggle_pkg.sv
// Shared definitions for the GPIO wiggle pattern generator:
// the mode encoding and the default pattern loaded at reset.
package wiggle_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic [31:0] DEFAULT_RESET_PATTERN = 32'hFFFF_FFFE;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable step prescaler: emits a registered one-cycle tick every div+1
// enabled cycles. clear restarts the period; a disabled cycle drops any tick.
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Period counter; when div drops below cnt the counter wraps before matching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == div) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      cnt  <= cnt;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_pattern_gen.sv
// Walking-pattern generator for two GPIO banks: rotate, bounce or count,
// advancing once per prescaler period, with an end-of-lap strobe.
module gpio_pattern_gen
  import wiggle_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               DIV_W         = 24,
  parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(DEFAULT_RESET_PATTERN),
  parameter bit               INVERT_B      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] gpio_a,
  output logic [WIDTH-1:0] gpio_b,
  output logic             step_tick,
  output logic             wrap
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LIM_ROT = SW'(WIDTH - 1);
  localparam logic [SW-1:0] LIM_BNC = SW'(WIDTH - 2);

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] next_pattern;
  logic [SW-1:0]    step;
  logic [SW-1:0]    next_step;
  logic [SW-1:0]    lap_limit;
  logic             dir;
  logic             next_dir;
  logic             next_wrap;
  mode_e            cur_mode;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] p);
    return {p[WIDTH-2:0], p[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] p);
    return {p[0], p[WIDTH-1:1]};
  endfunction

  assign cur_mode = mode_e'(mode);
  assign gpio_a   = pattern;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .div    (div),
    .tick   (step_tick)
  );

  // Next pattern and lap bookkeeping; a tick only takes effect while still enabled.
  always_comb begin
    next_pattern = pattern;
    next_step    = step;
    next_dir     = dir;
    next_wrap    = 1'b0;
    lap_limit    = LIM_ROT;
    if (step_tick && enable) begin
      case (cur_mode)
        MODE_ROTL:   next_pattern = rot_left(pattern);
        MODE_ROTR:   next_pattern = rot_right(pattern);
        MODE_BOUNCE: begin
          lap_limit = LIM_BNC;
          if (dir) begin
            next_pattern = rot_right(pattern);
          end else begin
            next_pattern = rot_left(pattern);
          end
        end
        MODE_COUNT: begin
          next_pattern = pattern + WIDTH'(1);
          next_wrap    = &pattern;
        end
        default:     next_pattern = pattern;
      endcase
      // Count mode ignores the lap counter; >= also catches a step left over from a longer-lap mode.
      if (cur_mode == MODE_COUNT) begin
        next_step = step;
      end else if (step >= lap_limit) begin
        next_step = '0;
        next_wrap = 1'b1;
        next_dir  = (cur_mode == MODE_BOUNCE) ? ~dir : dir;
      end else begin
        next_step = step + SW'(1);
      end
    end else begin
      next_pattern = pattern;
    end
  end

  // Pattern state and registered outputs; load restarts everything regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= RESET_PATTERN;
      gpio_b  <= INVERT_B ? ~RESET_PATTERN : RESET_PATTERN;
      step    <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
    end else if (load) begin
      pattern <= seed;
      gpio_b  <= INVERT_B ? ~seed : seed;
      step    <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      pattern <= next_pattern;
      gpio_b  <= INVERT_B ? ~next_pattern : next_pattern;
      step    <= next_step;
      dir     <= next_dir;
      wrap    <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Randomized and directed checks of gpio_pattern_gen (WIDTH=32, INVERT_B=1)
// against a behavioural model of stepping, laps and prescaling.
module tb_gpio_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] div;
  logic        load;
  logic [31:0] seed;
  logic [31:0] gpio_a;
  logic [31:0] gpio_b;
  logic        step_tick;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_pat;
  int          m_cnt;
  int          m_steps;
  bit          m_dir;
  bit          m_tick;
  bit          m_wrap;

  gpio_pattern_gen #(
    .WIDTH(32), .DIV_W(24), .RESET_PATTERN(32'hFFFF_FFFE), .INVERT_B(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .div(div),
    .load(load), .seed(seed), .gpio_a(gpio_a), .gpio_b(gpio_b),
    .step_tick(step_tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 32'hFFFF_FFFE; m_cnt = 0; m_steps = 0; m_dir = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  // One clock edge of the behavioural model, using the inputs presented to it.
  task automatic model_edge();
    bit do_step;
    bit hit;
    int lim;
    if (load) begin
      m_pat = seed; m_cnt = 0; m_steps = 0; m_dir = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
    end else if (!enable) begin
      m_tick = 1'b0; m_wrap = 1'b0;
    end else begin
      do_step = m_tick;
      hit = (m_cnt == int'(div));
      m_cnt = hit ? 0 : (m_cnt + 1) % (1 << 24);
      m_tick = hit;
      m_wrap = 1'b0;
      if (do_step) begin
        if (mode == 2'd3) begin
          m_wrap = (m_pat == 32'hFFFF_FFFF);
          m_pat = m_pat + 32'd1;
        end else begin
          if (mode == 2'd0 || (mode == 2'd2 && !m_dir))
            m_pat = (m_pat << 1) | (m_pat >> 31);
          else
            m_pat = (m_pat >> 1) | (m_pat << 31);
          lim = (mode == 2'd2) ? 30 : 31;
          if (m_steps >= lim) begin
            m_steps = 0;
            m_wrap = 1'b1;
            if (mode == 2'd2) m_dir = ~m_dir;
          end else begin
            m_steps = m_steps + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_value({tag, ".gpio_a"}, gpio_a, m_pat);
    check_value({tag, ".gpio_b"}, gpio_b, ~m_pat);
    check_value({tag, ".step_tick"}, {31'd0, step_tick}, {31'd0, m_tick});
    check_value({tag, ".wrap"}, {31'd0, wrap}, {31'd0, m_wrap});
  endtask

  // Starts and ends on a falling edge; inputs held across the rising edge.
  task automatic cycle(input logic en, input logic [1:0] md, input logic ld, input logic [31:0] sd);
    enable = en; mode = md; load = ld; seed = sd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n, input logic en, input logic [1:0] md);
    for (int k = 0; k < n; k++) cycle(en, md, 1'b0, 32'd0);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [1:0] md, input logic [31:0] sd);
    div = d;
    cycle(1'b1, md, 1'b1, sd);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    check_value({tag, ".const_a"}, gpio_a, 32'hFFFF_FFFE);
    check_value({tag, ".const_b"}, gpio_b, 32'h0000_0001);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] md;
    int r;
    rst = 1'b1; enable = 1'b1; mode = 2'd0; div = 24'd3; load = 1'b0; seed = 32'd0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    check_value("reset.const_a", gpio_a, 32'hFFFF_FFFE);
    rst = 1'b0;

    // rotl, div=3: first step after edge 5, then every 4 edges, lap after 32 steps
    run(4, 1'b1, 2'd0);
    check_value("rotl.e4", gpio_a, 32'hFFFF_FFFE);
    run(1, 1'b1, 2'd0);
    check_value("rotl.e5", gpio_a, 32'hFFFF_FFFD);
    run(4, 1'b1, 2'd0);
    check_value("rotl.e9", gpio_a, 32'hFFFF_FFFB);
    run(120, 1'b1, 2'd0);
    check_value("rotl.lap_wrap", {31'd0, wrap}, 32'd1);
    check_value("rotl.lap_pat", gpio_a, 32'hFFFF_FFFE);
    run(1, 1'b1, 2'd0);
    check_value("rotl.wrap_once", {31'd0, wrap}, 32'd0);

    // rotr, div=0
    do_load(24'd0, 2'd1, 32'hFFFF_FFFE);
    run(2, 1'b1, 2'd1);
    check_value("rotr.s1", gpio_a, 32'h7FFF_FFFF);
    run(1, 1'b1, 2'd1);
    check_value("rotr.s2", gpio_a, 32'hBFFF_FFFF);
    run(70, 1'b1, 2'd1);

    // bounce, div=0
    do_load(24'd0, 2'd2, 32'hFFFF_FFFE);
    run(32, 1'b1, 2'd2);
    check_value("bounce.out_pat", gpio_a, 32'h7FFF_FFFF);
    check_value("bounce.out_wrap", {31'd0, wrap}, 32'd1);
    run(31, 1'b1, 2'd2);
    check_value("bounce.back_pat", gpio_a, 32'hFFFF_FFFE);
    check_value("bounce.back_wrap", {31'd0, wrap}, 32'd1);

    // count, div=1
    do_load(24'd1, 2'd3, 32'hFFFF_FFFD);
    run(3, 1'b1, 2'd3);
    check_value("count.s1", gpio_a, 32'hFFFF_FFFE);
    run(2, 1'b1, 2'd3);
    check_value("count.s2", gpio_a, 32'hFFFF_FFFF);
    check_value("count.s2_wrap", {31'd0, wrap}, 32'd0);
    run(2, 1'b1, 2'd3);
    check_value("count.s3", gpio_a, 32'h0000_0000);
    check_value("count.s3_wrap", {31'd0, wrap}, 32'd1);

    // enable dropped with a tick pending: the step is lost, not replayed
    do_load(24'd3, 2'd0, 32'hFFFF_FFFE);
    run(4, 1'b1, 2'd0);
    check_value("hold.tick_pending", {31'd0, step_tick}, 32'd1);
    run(10, 1'b0, 2'd0);
    check_value("hold.frozen", gpio_a, 32'hFFFF_FFFE);
    run(4, 1'b1, 2'd0);
    check_value("hold.no_replay", gpio_a, 32'hFFFF_FFFE);
    run(1, 1'b1, 2'd0);
    check_value("hold.resume", gpio_a, 32'hFFFF_FFFD);

    // load on a tick cycle wins over the step
    run(3, 1'b1, 2'd0);
    check_value("ldtick.pending", {31'd0, step_tick}, 32'd1);
    do_load(24'd3, 2'd0, 32'hA5A5_5A5A);
    check_value("ldtick.seed", gpio_a, 32'hA5A5_5A5A);

    // async reset mid-lap
    run(9, 1'b1, 2'd0);
    async_reset("rst_mid");
    run(6, 1'b1, 2'd0);

    // randomized phase; div only changes together with a load
    md = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        md = 2'($urandom_range(0, 3));
        do_load(24'($urandom_range(0, 4)), md, (r == 0) ? 32'hFFFF_FFF8 : $urandom);
      end else if (r < 7) begin
        md = 2'($urandom_range(0, 3));
        cycle(1'b1, md, 1'b0, 32'd0);
      end else if (r < 17) begin
        cycle(1'b0, md, 1'b0, 32'd0);
      end else begin
        cycle(1'b1, md, 1'b0, 32'd0);
      end
      if (i == 1500) async_reset("rst_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_gen.md
Name: gpio_pattern_gen

Overview:
- Parametrised successor of the board's LED/GPIO "wiggle" shifter.
- Generates a WIDTH-bit walking pattern on two GPIO banks, advancing once per programmable prescaler period.
- Four runtime modes: rotate-left, rotate-right, bounce, binary count. Supports seed load, enable/hold, and an end-of-lap strobe.
- Sits at top level beside the PCIe core, clocked from the board clock, reset from inverted PERST#.

Parameters:
- WIDTH, 32, pattern and GPIO bank width (>=2).
- DIV_W, 24, prescaler counter width.
- RESET_PATTERN, 32'hFFFF_FFFE (WIDTH bits), pattern value after reset.
- INVERT_B, 0, when 1 gpio_b drives ~pattern, otherwise pattern.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset (driven as ~perstn at top level).
- enable  input  1  1 = prescaler runs and pattern advances; 0 = hold all state.
- mode  input  2  0 rotl, 1 rotr, 2 bounce, 3 count; sampled on each step.
- div  input  DIV_W  step period minus one; quasi-static.
- load  input  1  one-cycle pulse: load seed, restart.
- seed  input  WIDTH  value loaded on load.
- gpio_a  output  WIDTH  current pattern.
- gpio_b  output  WIDTH  pattern, or ~pattern if INVERT_B.
- step_tick  output  1  registered; high the cycle a step is applied.
- wrap  output  1  registered; one-cycle pulse after the step that completes a lap.

Behaviour:
- Reset (async): pattern=RESET_PATTERN, cnt=0, step=0, dir=0 (left), step_tick=0, wrap=0. gpio_a/gpio_b therefore show RESET_PATTERN (inverted on gpio_b if INVERT_B).
- Prescaler, per enabled edge:
  - cnt==div: cnt<=0, step_tick<=1.
  - otherwise: cnt<=cnt+1, step_tick<=0.
  - Period is div+1 cycles. div=0 gives step_tick high every cycle.
  - If div is lowered below cnt, cnt counts up and wraps modulo 2^DIV_W before matching (legal but slow; documented).
- Step: applied on the edge where step_tick==1 and enable==1. With div=3 and enable held from reset release, the first change is visible after edge 5 (div+2); subsequent changes every div+1 edges.
- Mode actions on a step:
  - rotl: pattern <= {pattern[W-2:0], pattern[W-1]}.
  - rotr: pattern <= {pattern[0], pattern[W-1:1]}.
  - bounce: rotate in direction dir (0=left).
  - count: pattern <= pattern+1, modulo 2^WIDTH.
- Lap counter step, with limit = WIDTH-1 for rotl/rotr and WIDTH-2 for bounce:
  - On a step with step>=limit: step<=0, wrap<=1, and in bounce dir<=~dir.
  - Otherwise: step<=step+1.
  - Count mode: step is unused; wrap<=1 on the step where pattern was all-ones (i.e. rolls to 0).
  - wrap is 0 on every edge where no lap completes.
- Bounce with WIDTH=32, seed FFFF_FFFE: the zero walks to bit 31 in 31 steps (7FFF_FFFF), then walks back in 31 steps.
- enable=0: cnt, pattern, step, dir hold; step_tick<=0, wrap<=0. A pending step_tick is discarded and not replayed.
- load (priority over everything except rst): pattern<=seed, cnt<=0, step<=0, dir<=0, step_tick<=0, wrap<=0, regardless of enable.
- Mode change without load: step and dir are kept; the new limit applies at the next step (step>=limit rule covers step beyond the new limit).
- rst asserted mid-period or mid-lap: immediate return to reset values; no glitch pulse on wrap or step_tick.

Decomposition:
- Shared package wiggle_pkg: mode encoding constants (MODE_ROTL=0, MODE_ROTR=1, MODE_BOUNCE=2, MODE_COUNT=3) and default RESET_PATTERN.
- One natural sub-module, tick_prescaler: DIV_W counter with enable, sync clear (from load), outputs the registered step_tick.
- Pattern/lap logic stays in gpio_pattern_gen.

Test Plan:
- Reset, enable=1, div=3, mode=0: pattern FFFF_FFFE, then FFFF_FFFD after edge 5, FFFF_FFFB after edge 9. step_tick high every 4th cycle. wrap pulses after the 32nd step with pattern back at FFFF_FFFE.
- mode=1, div=0: FFFF_FFFE -> 7FFF_FFFF -> BFFF_FFFF on consecutive cycles. wrap every 32 cycles.
- mode=2, div=0: 31 steps reach 7FFF_FFFF, wrap pulses once, next 31 steps return to FFFF_FFFE, wrap pulses again.
- mode=3, load seed=FFFF_FFFD, div=1: FFFF_FFFE, FFFF_FFFF, 0000_0000. wrap high only after the roll to zero.
- enable dropped for 10 cycles mid-period with step_tick pending: pattern and cnt frozen, step_tick/wrap 0. On re-enable, the step occurs after the remaining count, not immediately.
- load during a step_tick cycle, and rst asserted mid-lap: load wins (pattern=seed, cnt=0). rst returns all outputs to reset values asynchronously. With INVERT_B=1, gpio_b == ~gpio_a throughout.
